ppwm_pwm_gen: RTL

//   Multi-channel PWM generator fed by the tick-gated counting stage upstream.
//   - Internal period counter advances on each tick_i; NUM_CH channels compare it to duty values.
//   - Period (TOP) and per-channel duty are written over a simple byte write port.
//   - Both are double-buffered and take effect only at a period boundary, so no glitched periods.

---
 rtl/ppwm_pkg.sv | 26 ++
 rtl/ppwm_compare.sv | 32 +++
 rtl/ppwm_pwm_gen.sv | 68 ++++++
 3 files changed

// File: rtl/ppwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package ppwm_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 8;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  function automatic logic [2:0] addr_top_of(input int num_ch);
    return 3'(num_ch);
  endfunction

  function automatic logic [2:0] addr_ctrl_of(input int num_ch);
    return 3'(num_ch + 1);
  endfunction

  localparam logic [2:0] ADDR_DUTY0 = 3'd0;
  localparam logic [2:0] ADDR_TOP   = addr_top_of(NUM_CH_DEF);
  localparam logic [2:0] ADDR_CTRL  = addr_ctrl_of(NUM_CH_DEF);

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

  localparam cnt_t TOP_RST = '1;

endpackage

// File: rtl/ppwm_compare.sv
// One PWM channel: double-buffered duty register, comparator and output flop.
module ppwm_compare #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             load_act,
  input  logic             en,
  input  logic             inv,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] duty_act;

  // duty_act samples the pre-write shadow when a write and a load coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh  <= '0;
      duty_act <= '0;
      pwm      <= 1'b0;
    end else begin
      if (wr_en)    duty_sh  <= wr_data;
      if (load_act) duty_act <= duty_sh;
      pwm <= (en & (cnt < duty_act)) ^ inv;
    end
  end

endmodule

// File: rtl/ppwm_pwm_gen.sv
// Multi-channel PWM generator: period counter, TOP/CTRL registers and write decode.
module ppwm_pwm_gen
  import ppwm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic              wr_en_i,
  input  logic [2:0]        wr_addr_i,
  input  logic [CNT_W-1:0]  wr_data_i,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              period_end_o
);

  localparam logic [2:0] A_TOP  = addr_top_of(NUM_CH);
  localparam logic [2:0] A_CTRL = addr_ctrl_of(NUM_CH);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] top_sh;
  logic [CNT_W-1:0] top_act;
  logic             en;
  logic             inv;
  logic             wrap;
  logic             load_act;

  assign wrap     = en & tick_i & (cnt == top_act);
  // While disabled the active copies track the shadows so EN 0->1 starts fresh
  assign load_act = ~en | wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      top_sh       <= '1;
      top_act      <= '1;
      en           <= 1'b0;
      inv          <= 1'b0;
      period_end_o <= 1'b0;
    end else begin
      if (wr_en_i && (wr_addr_i == A_TOP)) top_sh <= wr_data_i;
      if (wr_en_i && (wr_addr_i == A_CTRL)) begin
        en  <= wr_data_i[CTRL_EN];
        inv <= wr_data_i[CTRL_INV];
      end
      if (load_act) top_act <= top_sh;
      if (!en)         cnt <= '0;
      else if (tick_i) cnt <= wrap ? '0 : cnt + 1'b1;
      period_end_o <= wrap;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ppwm_compare #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en_i && (wr_addr_i == 3'(i))),
      .wr_data  (wr_data_i),
      .load_act (load_act),
      .en       (en),
      .inv      (inv),
      .cnt      (cnt),
      .pwm      (pwm_o[i])
    );
  end

endmodule
